// File: rtl/shift_restore_if.sv
// Handshake bundle between the PE accumulator/tag source and shift_restore.
// The master side drives tags, accumulator beats and downstream ready; the slave side is shift_restore.
interface shift_restore_if #(
    parameter int ACC_BW = 32
);
    logic [1:0]        gemm_uno;
    logic              tag_valid_i;
    logic              tag_ready_o;
    logic [4:0]        shift_i;
    logic              acc_valid_i;
    logic              acc_ready_o;
    logic [ACC_BW-1:0] acc_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [ACC_BW-1:0] res_o;

    modport master (
        output gemm_uno, tag_valid_i, shift_i, acc_valid_i, acc_i, res_ready_i,
        input  tag_ready_o, acc_ready_o, res_valid_o, res_o
    );

    modport slave (
        input  gemm_uno, tag_valid_i, shift_i, acc_valid_i, acc_i, res_ready_i,
        output tag_ready_o, acc_ready_o, res_valid_o, res_o
    );
endinterface

// File: rtl/shift_restore.sv
// Re-applies the issue-time leading-one exponent to normalized div results.
// In-order tag FIFO plus a one-entry registered valid/ready result stage.
module shift_restore #(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 10,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_restore_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = $clog2(MUL_BW) + 1;
    // Exponent spans -FRA_BW..+INT_BW with headroom for any tag value.
    localparam int E_W   = $clog2((FRA_BW > INT_BW) ? FRA_BW : INT_BW) + 2;

    localparam logic [ACC_BW-1:0] SAT_POS = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic [ACC_BW-1:0] SAT_NEG = {1'b1, {(ACC_BW-1){1'b0}}};

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             res_valid;
    logic [ACC_BW-1:0] res;

    logic is_div, tag_ready, acc_ready;
    logic push, pop, acc_fire;
    logic [TAG_W-1:0] head_tag;
    logic signed [E_W-1:0] e;
    logic [E_W-1:0] lsh, rsh;
    logic signed [ACC_BW-1:0] acc_s, lshifted;
    logic [ACC_BW-1:0] denorm;

    assign is_div    = (bus.gemm_uno == 2'b01);
    assign tag_ready = (count != CNT_W'(DEPTH));
    assign acc_ready = (~res_valid | bus.res_ready_i) & (~is_div | (count != '0));
    assign push      = bus.tag_valid_i & tag_ready;
    assign acc_fire  = bus.acc_valid_i & acc_ready;
    assign pop       = acc_fire & is_div;

    assign head_tag = mem[rd_ptr];
    assign e        = signed'(E_W'(head_tag)) - signed'(E_W'(FRA_BW));
    assign lsh      = unsigned'(-e);
    assign rsh      = unsigned'(e);
    assign acc_s    = bus.acc_i;

    // Left shift saturates when shifting back does not recover the operand,
    // i.e. some shifted-out bit differs from the new sign bit.
    always_comb begin
        lshifted = acc_s <<< lsh;
        denorm   = bus.acc_i;
        if (is_div && e > 0) begin
            denorm = acc_s >>> rsh;
        end else if (is_div && e < 0) begin
            if ((lshifted >>> lsh) != acc_s) begin
                denorm = acc_s[ACC_BW-1] ? SAT_NEG : SAT_POS;
            end else begin
                denorm = lshifted;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.shift_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            res       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (acc_fire) begin
                res       <= denorm;
                res_valid <= 1'b1;
            end else if (bus.res_ready_i) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign bus.tag_ready_o = tag_ready;
    assign bus.acc_ready_o = acc_ready;
    assign bus.res_valid_o = res_valid;
    assign bus.res_o       = res;
endmodule

// File: tb/tb_shift_restore.sv
// Scoreboard bench for shift_restore: directed test-plan cases, then randomized traffic
// against an arithmetic reference model of the exponent restore.
module tb_shift_restore;
    localparam int ACC_BW = 32;
    localparam int DEPTH  = 4;
    localparam int FRA_BW = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    shift_restore_if #(.ACC_BW(ACC_BW)) bus ();

    shift_restore #(
        .INT_BW(5), .FRA_BW(FRA_BW), .MUL_BW(16), .ACC_BW(ACC_BW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    logic [4:0]  tag_q[$];
    logic [31:0] sb[$];
    logic        hold_prev = 1'b0;
    logic [31:0] prev_res  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Value-level model: div scales by 2^-(shift-FRA_BW) with floor rounding,
    // clamping to the signed 32-bit range.
    function automatic logic [31:0] ref_denorm(input logic [1:0] mode, input logic [4:0] shift,
                                               input logic [31:0] acc);
        longint a, d, q, v;
        int e;
        if (mode != 2'b01) return acc;
        a = longint'($signed(acc));
        e = int'(shift) - FRA_BW;
        if (e >= 0) begin
            d = longint'(1) << e;
            q = a / d;
            if ((a % d) != 0 && a < 0) q = q - 1;
            return q[31:0];
        end
        v = a * (longint'(1) << (-e));
        if (v > longint'(2147483647)) return 32'h7FFF_FFFF;
        if (v < -longint'(2147483647) - 1) return 32'h8000_0000;
        return v[31:0];
    endfunction

    // Stimulus side: records accepted tags and pushes expected results.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.acc_valid_i && bus.acc_ready_o) begin
                if (bus.gemm_uno == 2'b01) begin
                    if (tag_q.size() == 0) check("div_accept_with_empty_fifo", tag_q.size(), 1);
                    else sb.push_back(ref_denorm(bus.gemm_uno, tag_q.pop_front(), bus.acc_i));
                end else begin
                    sb.push_back(bus.acc_i);
                end
            end
            if (bus.tag_valid_i && bus.tag_ready_o) tag_q.push_back(bus.shift_i);
        end
    end

    // Monitor: handshake expectations and result comparison.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            check("tag_ready", bus.tag_ready_o, tag_q.size() != DEPTH);
            check("acc_ready", bus.acc_ready_o,
                  (sb.size() == 0 || bus.res_ready_i) && (bus.gemm_uno != 2'b01 || tag_q.size() != 0));
            check("res_valid", bus.res_valid_o, sb.size() != 0);
            if (hold_prev) check("res_held_stable", bus.res_o, prev_res);
            if (bus.res_valid_o && bus.res_ready_i) begin
                if (sb.size() == 0) check("spurious_result", sb.size(), 1);
                else check("result", bus.res_o, sb.pop_front());
            end
            hold_prev = bus.res_valid_o && !bus.res_ready_i;
            prev_res  = bus.res_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tag(input logic [4:0] s);
        logic ok;
        ok = 1'b0;
        bus.tag_valid_i = 1'b1;
        bus.shift_i     = s;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.tag_ready_o;
            if (!ok) step();
        end
        if (!ok) check("tag_push_timeout", ok, 1);
        step();
        bus.tag_valid_i = 1'b0;
    endtask

    task automatic acc_beat(input logic [1:0] mode, input logic [31:0] data);
        logic ok;
        ok = 1'b0;
        bus.gemm_uno    = mode;
        bus.acc_i       = data;
        bus.acc_valid_i = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.acc_ready_o;
            if (!ok) step();
        end
        if (!ok) check("acc_beat_timeout", ok, 1);
        step();
        bus.acc_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.tag_valid_i = 1'b0;
        bus.acc_valid_i = 1'b0;
        tag_q.delete();
        sb.delete();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_acc();
        logic [31:0] v;
        v = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    initial begin
        int n;
        int cyc;
        bus.gemm_uno    = 2'b00;
        bus.tag_valid_i = 1'b0;
        bus.shift_i     = '0;
        bus.acc_valid_i = 1'b0;
        bus.acc_i       = '0;
        bus.res_ready_i = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_res_valid", bus.res_valid_o, 0);
        check("reset_res_o", bus.res_o, 0);
        check("reset_tag_ready", bus.tag_ready_o, 1);
        check("reset_acc_ready_gemm", bus.acc_ready_o, 1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Pass-through and directed div cases.
        acc_beat(2'b00, 32'h0000_1234);
        push_tag(5'd12);
        acc_beat(2'b00, 32'h0000_5555);
        acc_beat(2'b10, 32'hDEAD_BEEF);
        acc_beat(2'b01, 32'h0000_4000);
        push_tag(5'd12);
        acc_beat(2'b01, 32'hFFFF_FC00);
        push_tag(5'd5);
        acc_beat(2'b01, 32'h0000_0100);
        push_tag(5'd0);
        acc_beat(2'b01, 32'h0100_0000);
        push_tag(5'd0);
        acc_beat(2'b01, 32'hFF00_0000);
        step();
        step();

        // Fill the FIFO with five back-to-back tags; the fifth must be refused.
        n = 0;
        bus.gemm_uno    = 2'b00;
        bus.tag_valid_i = 1'b1;
        bus.shift_i     = 5'd10;
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(negedge clk);
            if (bus.tag_ready_o) n++;
            step();
            bus.shift_i = 5'(10 + n);
        end
        check("fill_accepts", n, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_tag_ready_low", bus.tag_ready_o, 0);
            step();
        end
        bus.tag_valid_i = 1'b0;

        // Drain in div mode with acc_valid held; expect one accept per cycle.
        n = 0;
        cyc = 0;
        bus.gemm_uno    = 2'b01;
        bus.acc_i       = 32'h0000_2000;
        bus.acc_valid_i = 1'b1;
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(negedge clk);
            if (bus.acc_ready_o) n++;
            cyc++;
            step();
        end
        check("drain_accepts", n, 4);
        check("drain_cycles", cyc, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("empty_acc_ready_low", bus.acc_ready_o, 0);
            step();
        end
        bus.acc_valid_i = 1'b0;
        step();

        // Backpressure: result held for three cycles with a second beat waiting.
        push_tag(5'd11);
        push_tag(5'd13);
        bus.res_ready_i = 1'b0;
        acc_beat(2'b01, 32'h0001_2340);
        bus.acc_i       = 32'h00AB_CDE0;
        bus.acc_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_acc_stall", bus.acc_ready_o, 0);
            check("bp_valid_held", bus.res_valid_o, 1);
            step();
        end
        bus.res_ready_i = 1'b1;
        @(negedge clk);
        check("bp_release_accept", bus.acc_ready_o, 1);
        step();
        bus.acc_valid_i = 1'b0;
        step();
        step();

        // Randomized traffic; mode only changes with acc_valid low.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 25 == 0) begin
                bus.acc_valid_i = 1'b0;
                step();
                bus.gemm_uno = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3));
            end
            bus.tag_valid_i = ($urandom_range(0, 2) != 0);
            bus.shift_i     = 5'($urandom_range(0, 15));
            bus.acc_valid_i = ($urandom_range(0, 1) == 1);
            bus.acc_i       = rand_acc();
            bus.res_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.tag_valid_i = 1'b0;
        bus.acc_valid_i = 1'b0;
        bus.res_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Reset mid-operation with two tags stored and a result held.
        do_reset();
        bus.res_ready_i = 1'b1;
        push_tag(5'd10);
        push_tag(5'd11);
        push_tag(5'd12);
        bus.res_ready_i = 1'b0;
        acc_beat(2'b01, 32'h0000_0400);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_res_valid", bus.res_valid_o, 0);
        check("midreset_res_o", bus.res_o, 0);
        check("midreset_tag_ready", bus.tag_ready_o, 1);
        check("midreset_acc_ready_div", bus.acc_ready_o, 0);
        tag_q.delete();
        sb.delete();
        step();
        rst_n = 1'b1;
        bus.res_ready_i = 1'b1;
        bus.acc_i       = 32'h0000_0077;
        bus.acc_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_div_stall", bus.acc_ready_o, 0);
            step();
        end
        bus.acc_valid_i = 1'b0;
        push_tag(5'd10);
        acc_beat(2'b01, 32'h0000_0077);
        for (int i = 0; i < 4; i++) step();
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_restore.md
Name: shift_restore

Overview:
Output-side counterpart to the PE's input offset generator.
- At issue time, the leading-one position of each x operand (the 5-bit priority-encoder output) is pushed into this block as a shift tag.
- When the accumulator later produces the normalized result, this block pops the matching tag and re-applies the exponent, producing the denormalized PE result.
- It sits between the PE accumulator and the PE result port. It buffers tags in an in-order FIFO and presents results through a registered valid/ready stage.

Parameters:
INT_BW, 5, integer bits of the fixed-point format
FRA_BW, 10, fraction bits; normalized operand has its leading one at bit FRA_BW
MUL_BW, 16, operand width
ACC_BW, 32, accumulator/result width
DEPTH, 4, tag FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
gemm_uno  in  2  mode: 00 gemm, 01 div, 10 exp, 11 log; held stable while beats are in flight
tag_valid_i  in  1  shift tag valid
tag_ready_o  out  1  tag accepted when valid&ready
shift_i  in  5  leading-one index of |x| (0..15)
acc_valid_i  in  1  accumulator result valid
acc_ready_o  out  1  accumulator result accepted when valid&ready
acc_i  in  ACC_BW  signed normalized accumulator result
res_valid_o  out  1  result valid
res_ready_i  in  1  downstream ready
res_o  out  ACC_BW  signed denormalized result

Behaviour:
- Reset (async, rst_n low): FIFO pointers and count = 0, res_valid_o = 0, res_o = 0. tag_ready_o = 1 after reset.
- Reset mid-operation discards all stored tags and any held result immediately.

Tag FIFO:
- Push on tag_valid_i & tag_ready_o, with tag_ready_o = (count != DEPTH).
- No bypass: a tag pushed in cycle N is poppable from cycle N+1.
- Simultaneous push and pop when count is in 1..DEPTH-1: count is unchanged.
- When full, tag_ready_o = 0 even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH.

Mode handling per acc beat:
- 00, 10, 11: pass-through. res = acc_i, no tag consumed, FIFO untouched.
- 01 (div): pop one tag. Compute e = shift - FRA_BW as signed 6-bit, range -10..+5.
  - e > 0: res = acc_i >>> e (arithmetic).
  - e < 0: res = acc_i << -e, with saturation. If the shifted-out bits are not all equal to the result sign bit, res = 0x7FFF_FFFF for non-negative acc_i, 0x8000_0000 for negative acc_i (for ACC_BW = 32).
  - e = 0: res = acc_i.

Handshake:
- acc_ready_o = (~res_valid_o | res_ready_i) & (gemm_uno != 01 | count != 0).
- A div beat with an empty FIFO stalls; acc_ready_o = 0.
- On acc accept: res_o and res_valid_o = 1 are registered in the next cycle (latency 1).
- res_o and res_valid_o are held stable while res_valid_o & ~res_ready_i.
- If res_ready_i & ~new accept, res_valid_o clears.
- Full throughput is one result per cycle when downstream is ready and tags are available.
- acc_ready_o never depends combinationally on acc_valid_i.

Results are strictly in order; the tag order equals the div operand issue order.

Test Plan:
- gemm mode, acc_i = 0x0000_1234, res_ready_i = 1 -> res_o = 0x0000_1234 one cycle later; tag FIFO count stays 0 while tags are pushed.
- div, push shift = 12 (e = +2), then acc_i = 0x0000_4000 -> res_o = 0x0000_1000. Repeat with acc_i = 0xFFFF_FC00 -> res_o = 0xFFFF_FF00.
- div, push shift = 5 (e = -5), acc_i = 0x0000_0100 -> res_o = 0x0000_2000. Push shift = 0 (e = -10), acc_i = 0x0100_0000 -> res_o = 0x7FFF_FFFF. Same with acc_i = 0xFF00_0000 -> res_o = 0x8000_0000.
- DEPTH = 4: push 5 tags back-to-back with no acc -> tag_ready_o drops after the 4th accept. Then in div, acc_valid_i held high -> 4 results in order (shifts 10, 11, 12, 13 on acc_i = 0x2000 give 0x2000, 0x1000, 0x800, 0x400), then acc_ready_o = 0 on empty.
- Backpressure: res_ready_i = 0 for 3 cycles with res_valid_o = 1 -> res_o stable and acc_ready_o = 0. Release -> next result the following cycle, no loss or duplication.
- Assert rst_n low with 2 tags stored and res_valid_o = 1 -> res_valid_o = 0 and res_o = 0 immediately; after release, a div acc_i stalls (FIFO empty).
